// File: rtl/drive_state_ctrl.sv
// Vehicle state stage: synchronises driver inputs and, once per slow tick, advances
// gear, speed and steering state that the 7-segment display stage reads.
module drive_state_ctrl #(
  parameter int TICK_CYCLES = 10_000_000,
  parameter int ACCEL       = 2,
  parameter int BRAKE_STEP  = 4,
  parameter int MAX_SPEED_D = 120,
  parameter int MAX_SPEED_R = 20,
  parameter int MAX_DEGREE  = 4
) (
  input  logic       clk100mhz,
  input  logic       reset,
  input  logic       gas,
  input  logic       brake,
  input  logic [1:0] gear_req,
  input  logic       steer_left,
  input  logic       steer_right,
  output logic [1:0] gear,
  output logic [7:0] speed,
  output logic [1:0] direction,
  output logic [2:0] degree,
  output logic       tick
);

  typedef enum logic [1:0] {G_DRIVE = 2'b00, G_PARK = 2'b01, G_REV = 2'b10} gear_t;
  typedef enum logic [1:0] {D_LEFT = 2'b00, D_RIGHT = 2'b01, D_FWD = 2'b10, D_BRAKE = 2'b11} dir_t;

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [7:0] ACC_B   = 8'(ACCEL);
  localparam logic [7:0] BRK_B   = 8'(BRAKE_STEP);
  localparam logic [7:0] CEIL_D  = 8'(MAX_SPEED_D);
  localparam logic [7:0] CEIL_R  = 8'(MAX_SPEED_R);
  localparam logic [2:0] DEG_MAX = 3'(MAX_DEGREE);

  // {gas, brake, gear_req[1:0], steer_left, steer_right}
  logic [5:0] in_raw, sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick_q, tick_d;
  gear_t gear_q, gear_d;
  logic [7:0] speed_q, speed_d;
  logic side_q, side_d;  // 0 = left, 1 = right
  logic [2:0] deg_q, deg_d;
  dir_t dir_q, dir_d;

  logic gas_s, brake_s, left_s, right_s;
  logic [1:0] req_s;
  logic [8:0] sum;
  logic [7:0] ceil;

  assign in_raw  = {gas, brake, gear_req, steer_left, steer_right};
  assign gas_s   = sync2_q[5];
  assign brake_s = sync2_q[4];
  assign req_s   = sync2_q[3:2];
  assign left_s  = sync2_q[1];
  assign right_s = sync2_q[0];

  always_comb begin
    sync1_d = in_raw;
    sync2_d = sync1_q;
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_d  = (cnt_q == CNT_LAST);
    gear_d  = gear_q;
    speed_d = speed_q;
    side_d  = side_q;
    deg_d   = deg_q;
    dir_d   = dir_q;
    ceil    = (gear_q == G_REV) ? CEIL_R : CEIL_D;
    sum     = {1'b0, speed_q} + {1'b0, ACC_B};

    // State advances the cycle after the tick pulse, so outputs move together.
    if (tick_q) begin
      if (brake_s)
        speed_d = (speed_q > BRK_B) ? speed_q - BRK_B : 8'd0;
      else if (gas_s && gear_q != G_PARK)
        speed_d = (sum > {1'b0, ceil}) ? ceil : sum[7:0];
      else
        speed_d = (speed_q != 8'd0) ? speed_q - 8'd1 : 8'd0;
      if (gear_q == G_PARK)
        speed_d = 8'd0;

      if (speed_q == 8'd0 && brake_s && req_s != 2'b11)
        gear_d = gear_t'(req_s);

      if (left_s && !right_s) begin
        if (side_q && deg_q != 3'd0) deg_d = deg_q - 3'd1;
        else begin
          side_d = 1'b0;
          deg_d  = (deg_q >= DEG_MAX) ? DEG_MAX : deg_q + 3'd1;
        end
      end else if (right_s && !left_s) begin
        if (!side_q && deg_q != 3'd0) deg_d = deg_q - 3'd1;
        else begin
          side_d = 1'b1;
          deg_d  = (deg_q >= DEG_MAX) ? DEG_MAX : deg_q + 3'd1;
        end
      end else begin
        deg_d = (deg_q != 3'd0) ? deg_q - 3'd1 : 3'd0;
      end

      if (brake_s)            dir_d = D_BRAKE;
      else if (deg_d != 3'd0) dir_d = side_d ? D_RIGHT : D_LEFT;
      else                    dir_d = D_FWD;
    end
  end

  always_ff @(posedge clk100mhz or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      gear_q  <= G_PARK;
      speed_q <= 8'd0;
      side_q  <= 1'b0;
      deg_q   <= 3'd0;
      dir_q   <= D_FWD;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      gear_q  <= gear_d;
      speed_q <= speed_d;
      side_q  <= side_d;
      deg_q   <= deg_d;
      dir_q   <= dir_d;
    end
  end

  assign gear      = gear_q;
  assign speed     = speed_q;
  assign direction = dir_q;
  assign degree    = deg_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_drive_state_ctrl.sv
// Scoreboard bench for drive_state_ctrl: a per-tick vehicle model queues the expected
// state when inputs are applied; entries are popped and compared after each tick.
module tb_drive_state_ctrl;

  logic clk = 1'b0, reset = 1'b1;
  logic gas = 0, brake = 0, steer_left = 0, steer_right = 0;
  logic [1:0] gear_req = 2'b11;
  logic [1:0] gear, direction;
  logic [7:0] speed;
  logic [2:0] degree;
  logic tick;

  drive_state_ctrl #(.TICK_CYCLES(4)) dut (
    .clk100mhz(clk), .reset(reset), .gas(gas), .brake(brake), .gear_req(gear_req),
    .steer_left(steer_left), .steer_right(steer_right), .gear(gear), .speed(speed),
    .direction(direction), .degree(degree), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] gear;
    logic [7:0] speed;
    logic [1:0] dir;
    logic [2:0] deg;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0, n_fail = 0;
  int m_gear = 1, m_speed = 0, m_deg = 0;
  bit m_side = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural reference of one update tick; pushes the expected outputs.
  task automatic model(input bit g, input bit b, input int req, input bit l, input bit r);
    int ns, ng, nd, ceil, dir;
    bit nside;
    exp_t e;
    ceil = (m_gear == 2) ? 20 : 120;
    if (b)                     ns = (m_speed > 4) ? m_speed - 4 : 0;
    else if (g && m_gear != 1) ns = (m_speed + 2 > ceil) ? ceil : m_speed + 2;
    else                       ns = (m_speed > 0) ? m_speed - 1 : 0;
    if (m_gear == 1) ns = 0;
    ng = m_gear;
    if (m_speed == 0 && b && req != 3) ng = req;
    nside = m_side;
    nd = m_deg;
    if (l && !r) begin
      if (m_side && m_deg > 0) nd = m_deg - 1;
      else begin nside = 0; nd = (m_deg < 4) ? m_deg + 1 : 4; end
    end else if (r && !l) begin
      if (!m_side && m_deg > 0) nd = m_deg - 1;
      else begin nside = 1; nd = (m_deg < 4) ? m_deg + 1 : 4; end
    end else nd = (m_deg > 0) ? m_deg - 1 : 0;
    dir = b ? 3 : (nd > 0) ? (nside ? 1 : 0) : 2;
    e.gear = 2'(ng); e.speed = 8'(ns); e.dir = 2'(dir); e.deg = 3'(nd);
    sb.push_back(e);
    m_gear = ng; m_speed = ns; m_deg = nd; m_side = nside;
  endtask

  // Apply inputs for one tick, wait (bounded) for the tick pulse, then compare.
  task automatic step(input bit g, input bit b, input logic [1:0] req, input bit l,
                      input bit r, output int n);
    exp_t e;
    gas = g; brake = b; gear_req = req; steer_left = l; steer_right = r;
    model(g, b, int'(req), l, r);
    n = 0;
    do begin @(negedge clk); n++; end while (!tick && n < 20);
    if (!tick) chk("tick_timeout", 0, 1);
    @(negedge clk);
    e = sb.pop_front();
    chk("gear", gear, e.gear);
    chk("speed", speed, e.speed);
    chk("direction", direction, e.dir);
    chk("degree", degree, e.deg);
    chk("tick_pulse", tick, 0);
  endtask

  task automatic steps(input int cnt, input bit g, input bit b, input logic [1:0] req,
                       input bit l, input bit r);
    int n;
    for (int i = 0; i < cnt; i++) step(g, b, req, l, r, n);
  endtask

  task automatic release_and_check_period();
    int n;
    gas = 0; brake = 0; gear_req = 2'b11; steer_left = 0; steer_right = 0;
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 2'b11, 0, 0, n);
    chk("tick_period", n, 4);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_gear", gear, 2'b01);
    chk("rst_speed", speed, 0);
    chk("rst_degree", degree, 0);
    chk("rst_dir", direction, 2'b10);
    chk("rst_tick", tick, 0);
    release_and_check_period();

    // PARK -> DRIVE, then build speed 40 / degree 3 and reset mid-drive
    steps(1, 0, 1, 2'b00, 0, 0);
    chk("to_drive", gear, 2'b00);
    steps(17, 1, 0, 2'b11, 0, 0);
    steps(3, 1, 0, 2'b11, 1, 0);
    chk("pre_rst_speed", speed, 40);
    chk("pre_rst_deg", degree, 3);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("mid_rst_gear", gear, 2'b01);
    chk("mid_rst_speed", speed, 0);
    chk("mid_rst_degree", degree, 0);
    chk("mid_rst_dir", direction, 2'b10);
    m_gear = 1; m_speed = 0; m_deg = 0; m_side = 0;
    release_and_check_period();

    // acceleration to the DRIVE ceiling, then coasting
    steps(1, 0, 1, 2'b00, 0, 0);
    steps(70, 1, 0, 2'b11, 0, 0);
    chk("drive_ceiling", speed, 120);
    steps(3, 0, 0, 2'b11, 0, 0);
    chk("coast", speed, 117);

    // gas + brake: brake wins down to 0
    steps(31, 1, 1, 2'b11, 0, 0);
    chk("brake_floor", speed, 0);
    steps(5, 1, 0, 2'b11, 0, 0);
    steps(4, 1, 1, 2'b11, 0, 0);
    chk("brake_10", speed, 0);

    // gear change waits for standstill, then REVERSE ceiling
    steps(15, 1, 0, 2'b11, 0, 0);
    steps(7, 0, 1, 2'b10, 0, 0);
    chk("gear_held_moving", gear, 2'b00);
    steps(3, 0, 1, 2'b10, 0, 0);
    chk("to_reverse", gear, 2'b10);
    steps(15, 1, 0, 2'b11, 0, 0);
    chk("reverse_ceiling", speed, 20);

    // steering
    steps(6, 0, 1, 2'b11, 0, 0);
    steps(6, 0, 0, 2'b11, 1, 0);
    chk("left_sat", degree, 4);
    steps(5, 0, 0, 2'b11, 0, 1);
    chk("right_flip_dir", direction, 2'b01);
    steps(5, 0, 0, 2'b11, 1, 1);
    chk("both_dir", direction, 2'b10);

    // request without brake ignored; PARK holds speed at 0
    steps(2, 0, 0, 2'b01, 0, 0);
    chk("no_brake_gear", gear, 2'b10);
    steps(1, 0, 1, 2'b01, 0, 0);
    steps(3, 1, 0, 2'b11, 0, 0);
    chk("park_gas", speed, 0);
    chk("park_gear", gear, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
